mem_arbiter_ctrl: RTL and testbench

Parametrised multi-requester memory controller: arbitrates NUM_REQ requesters (generalising the CPU/EXT pair) for a single-port line memory, muxes the winner's address/write line onto the memory port and routes read data back. Adds round-robin or fixed-priority selection, a bounded hold time under contention, and per-requester read-valid strobes. Sits between the requesters and the line RAM.

---
 rtl/mem_arbiter_ctrl_if.sv | 43 ++++
 rtl/mem_arbiter_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_ctrl_if
// Description : Bus bundle between NUM_REQ memory requesters, the arbiter and
//               a single-port line RAM.
//               slave  modport : arbiter side (takes requests, drives memory)
//               master modport : requester/RAM-model side
//   req/wr            per-requester request level and write flag
//   addr/wdata        flattened per-requester address / write line, slice i
//   mem_rdata         RAM read line, valid one cycle after the address
//   gnt               one-hot grant
//   mem_addr/wdata/we RAM port
//   rdata/rvalid      read line broadcast plus per-requester valid strobe
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_ctrl_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 66,
    parameter int ADDR_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        wr;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_we;
    logic [DATA_W-1:0]         rdata;
    logic [NUM_REQ-1:0]        rvalid;

    modport slave (
        input  req, wr, addr, wdata, mem_rdata,
        output gnt, mem_addr, mem_wdata, mem_we, rdata, rvalid
    );

    modport master (
        output req, wr, addr, wdata, mem_rdata,
        input  gnt, mem_addr, mem_wdata, mem_we, rdata, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_ctrl
// Description : Arbitrates NUM_REQ requesters onto one single-port line RAM.
//               Round-robin or fixed-priority winner selection, bounded hold
//               under contention, per-requester read-valid strobes.
// Ports       : clk    - clock, all state on rising edge
//               reset  - asynchronous active-low reset
//               bus    - mem_arbiter_ctrl_if.slave (requests, RAM port, reads)
//               state  - FSM state: 0 IDLE, 1 GRANT, 2 RELEASE
//               owner  - index of current/last owner
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_ctrl #(
    parameter int  NUM_REQ  = 2,
    parameter int  DATA_W   = 66,
    parameter int  ADDR_W   = 8,
    parameter int  RR_MODE  = 1,
    parameter int  MAX_HOLD = 16,
    localparam int OWN_W    = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ)
) (
    input  wire logic              clk,
    input  wire logic              reset,
    mem_arbiter_ctrl_if.slave      bus,
    output logic [1:0]             state,
    output logic [OWN_W-1:0]       owner
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int               HOLD_W      = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [OWN_W-1:0]  c_LAST_REQ  = OWN_W'(NUM_REQ - 1);

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_rvalid;
    logic [OWN_W-1:0]    r_owner;
    logic [OWN_W-1:0]    r_ptr;
    logic [HOLD_W-1:0]   r_hold;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [OWN_W-1:0]    w_base;
    logic [OWN_W-1:0]    w_win;
    logic [OWN_W-1:0]    w_idx;
    logic [NUM_REQ-1:0]  w_win_oh;
    int                  w_sum;
    logic                w_found;
    logic                w_any;
    logic                w_contend;
    logic                w_rel;
    logic                w_in_grant;
    logic [ADDR_W-1:0]   w_own_addr;
    logic [DATA_W-1:0]   w_own_wdata;

    // Fixed priority is round-robin with the search always starting at 0.
    assign w_base = (RR_MODE != 0) ? r_ptr : '0;
    assign w_any  = |bus.req;

    // First requester at or after w_base, wrapping around.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_sum   = 0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = int'(w_base) + i;
            w_idx = OWN_W'((w_sum >= NUM_REQ) ? (w_sum - NUM_REQ) : w_sum);
            if (!w_found && bus.req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_win_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
    assign w_own_addr  = bus.addr[r_owner*ADDR_W +: ADDR_W];
    assign w_own_wdata = bus.wdata[r_owner*DATA_W +: DATA_W];
    assign w_in_grant  = (r_state == ST_GRANT);

    // r_gnt is one-hot on the owner while granted, so masking with it leaves
    // only the competing requests.
    assign w_contend = |(bus.req & ~r_gnt);

    // Normal release and forced release lead to the same transition.
    assign w_rel = w_in_grant &&
                   (!bus.req[r_owner] ||
                    ((MAX_HOLD != 0) && (r_hold == c_HOLD_LAST) && w_contend));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_hold      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_rvalid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= w_win_oh;
                        r_owner <= w_win;
                        r_hold  <= '0;
                        r_ptr   <= (w_win == c_LAST_REQ) ? '0 : w_win + 1'b1;
                    end
                end
                ST_GRANT: begin
                    // Keep the last driven RAM address/data for the idle bus.
                    r_mem_addr  <= w_own_addr;
                    r_mem_wdata <= w_own_wdata;
                    if (bus.req[r_owner] && !bus.wr[r_owner]) begin
                        r_rvalid[r_owner] <= 1'b1;
                    end
                    if (r_hold != '1) begin
                        r_hold <= r_hold + 1'b1;
                    end
                    if (w_rel) begin
                        r_state <= ST_RELEASE;
                        r_gnt   <= '0;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rvalid    = r_rvalid;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_we    = w_in_grant & bus.wr[r_owner] & bus.req[r_owner];
    assign bus.mem_addr  = w_in_grant ? w_own_addr  : r_mem_addr;
    assign bus.mem_wdata = w_in_grant ? w_own_wdata : r_mem_wdata;
    assign state         = r_state;
    assign owner         = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter_ctrl
// Description : Scoreboard bench for mem_arbiter_ctrl. Three instances:
//               A: 2 requesters, round-robin, unlimited hold
//               B: 4 requesters, round-robin, MAX_HOLD=4
//               C: 4 requesters, fixed priority, unlimited hold
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_ctrl;

    logic       clk;
    logic       reset;
    int         cyc;
    int         n_checks;
    int         n_errors;
    logic [1:0] sta, stb, stc;
    logic [0:0] owna;
    logic [1:0] ownb, ownc;

    mem_arbiter_ctrl_if #(.NUM_REQ(2), .DATA_W(66), .ADDR_W(8)) ifa ();
    mem_arbiter_ctrl_if #(.NUM_REQ(4), .DATA_W(66), .ADDR_W(8)) ifb ();
    mem_arbiter_ctrl_if #(.NUM_REQ(4), .DATA_W(66), .ADDR_W(8)) ifc ();

    mem_arbiter_ctrl #(.NUM_REQ(2), .DATA_W(66), .ADDR_W(8), .RR_MODE(1), .MAX_HOLD(0))
        u_dut_a (.clk(clk), .reset(reset), .bus(ifa), .state(sta), .owner(owna));
    mem_arbiter_ctrl #(.NUM_REQ(4), .DATA_W(66), .ADDR_W(8), .RR_MODE(1), .MAX_HOLD(4))
        u_dut_b (.clk(clk), .reset(reset), .bus(ifb), .state(stb), .owner(ownb));
    mem_arbiter_ctrl #(.NUM_REQ(4), .DATA_W(66), .ADDR_W(8), .RR_MODE(0), .MAX_HOLD(0))
        u_dut_c (.clk(clk), .reset(reset), .bus(ifc), .state(stc), .owner(ownc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        int           sel;
        logic [127:0] v;
        string        tag;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] get(input int sel);
        case (sel)
            0:  return 128'(ifa.gnt);
            1:  return 128'(ifa.mem_we);
            2:  return 128'(ifa.mem_addr);
            3:  return 128'(ifa.mem_wdata);
            4:  return 128'(sta);
            5:  return 128'(ifa.rvalid);
            6:  return 128'(ifa.rdata);
            7:  return 128'(owna);
            10: return 128'(ifb.gnt);
            11: return 128'(stb);
            12: return 128'(ownb);
            20: return 128'(ifc.gnt);
            21: return 128'(stc);
            22: return 128'(ownc);
            default: return '1;
        endcase
    endfunction

    // Expectation for the DUT outputs seen dly edges from now.
    task automatic push(input string tag, input int sel, input logic [127:0] v, input int dly);
        exp_t e;
        e.due = cyc + dly;
        e.sel = sel;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic pushc(input int dly, input logic [3:0] g, input logic [1:0] s);
        push("C_gnt", 20, 128'(g), dly);
        push("C_state", 21, 128'(s), dly);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard drain plus the grant one-hot invariant, away from the edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk(sb[i].tag, get(sb[i].sel), sb[i].v);
                sb.delete(i);
            end
        end
        chk("gnt_onehot", 128'(($countones(ifa.gnt) <= 1) && ($countones(ifb.gnt) <= 1)
                               && ($countones(ifc.gnt) <= 1)), 128'd1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        ifa.req  = 2'b11;
        ifa.wr   = 2'b01;
        ifa.addr = {8'h22, 8'h10};
        ifa.wdata = {66'h2_1111_2222_3333_4444, 66'h3_0000_0000_DEAD_BEEF};
        ifa.mem_rdata = 66'h1_2345;
        ifb.req = '0; ifb.wr = '0; ifb.addr = '0; ifb.wdata = '0; ifb.mem_rdata = '0;
        ifc.req = '0; ifc.wr = '0; ifc.addr = '0; ifc.wdata = '0; ifc.mem_rdata = '0;

        // Reset held with both requesting.
        tick(); tick();
        push("A_rst_gnt", 0, 128'd0, 0);
        push("A_rst_we", 1, 128'd0, 0);
        push("A_rst_state", 4, 128'd0, 0);
        push("A_rst_rvalid", 5, 128'd0, 0);
        push("A_rst_maddr", 2, 128'd0, 0);
        push("A_rst_mwdata", 3, 128'd0, 0);
        push("A_rst_owner", 7, 128'd0, 0);

        // First edge after release grants requester 0, which writes.
        reset = 1'b1;
        push("A_first_gnt", 0, 128'h1, 1);
        push("A_first_state", 4, 128'd1, 1);
        push("A_first_owner", 7, 128'd0, 1);
        push("A_wr_we", 1, 128'd1, 1);
        push("A_wr_addr", 2, 128'h10, 1);
        push("A_wr_data", 3, 128'(66'h3_0000_0000_DEAD_BEEF), 1);
        push("A_wr_rvalid", 5, 128'd0, 2);
        tick();
        push("A_hold_gnt", 0, 128'h1, 1);
        push("A_hold_gnt", 0, 128'h1, 2);
        push("A_hold_state", 4, 128'd1, 2);
        tick(); tick();

        // Owner 0 drops: 2-cycle gap, then requester 1 reads.
        ifa.req = 2'b10;
        ifa.wr  = 2'b00;
        push("A_rel_gnt", 0, 128'd0, 1);
        push("A_rel_state", 4, 128'd2, 1);
        push("A_rel_we", 1, 128'd0, 1);
        push("A_rel_maddr", 2, 128'h10, 1);
        push("A_rel_rvalid", 5, 128'd0, 1);
        push("A_idle_gnt", 0, 128'd0, 2);
        push("A_idle_state", 4, 128'd0, 2);
        push("A_idle_maddr", 2, 128'h10, 2);
        push("A_idle_rvalid", 5, 128'd0, 2);
        push("A_g1_gnt", 0, 128'h2, 3);
        push("A_g1_state", 4, 128'd1, 3);
        push("A_g1_owner", 7, 128'd1, 3);
        push("A_g1_maddr", 2, 128'h22, 3);
        push("A_g1_we", 1, 128'd0, 3);
        push("A_g1_rvalid", 5, 128'd0, 3);
        push("A_rd_rvalid", 5, 128'h2, 4);
        push("A_rd_rdata", 6, 128'(66'h1_2345), 4);
        push("A_rd_gnt", 0, 128'h2, 4);
        push("A_rd_rvalid2", 5, 128'h2, 5);
        repeat (6) tick();

        // Asynchronous reset in the middle of a read.
        chk("A_pre_rst_gnt", 128'(ifa.gnt), 128'h2);
        chk("A_pre_rst_rvalid", 128'(ifa.rvalid), 128'h2);
        #1 reset = 1'b0;
        #1;
        chk("A_async_gnt", 128'(ifa.gnt), 128'd0);
        chk("A_async_rvalid", 128'(ifa.rvalid), 128'd0);
        chk("A_async_state", 128'(sta), 128'd0);
        chk("A_async_we", 128'(ifa.mem_we), 128'd0);
        ifa.req = '0;
        tick(); tick();
        reset = 1'b1;
        tick();

        // Round-robin with MAX_HOLD=4 and every requester always asking.
        ifb.req = 4'b1111;
        for (int d = 1; d <= 30; d++) begin
            int j, r, k;
            j = d - 1;
            r = j % 6;
            k = j / 6;
            push("B_gnt", 10, (r < 4) ? 128'(4'b0001 << (k % 4)) : 128'd0, d);
            push("B_state", 11, (r < 4) ? 128'd1 : ((r == 4) ? 128'd2 : 128'd0), d);
            if (r < 4) push("B_owner", 12, 128'(k % 4), d);
        end
        repeat (30) tick();
        ifb.req = '0;
        tick();

        // Fixed priority.
        ifc.req = 4'b0110;
        pushc(1, 4'b0010, 2'd1);
        tick();
        ifc.req = 4'b0100;
        pushc(1, 4'b0000, 2'd2);
        pushc(2, 4'b0000, 2'd0);
        pushc(3, 4'b0100, 2'd1);
        repeat (3) tick();
        ifc.req = 4'b0101;
        pushc(1, 4'b0100, 2'd1);
        pushc(2, 4'b0100, 2'd1);
        repeat (2) tick();
        ifc.req = 4'b0001;
        pushc(1, 4'b0000, 2'd2);
        pushc(2, 4'b0000, 2'd0);
        pushc(3, 4'b0001, 2'd1);
        repeat (3) tick();
        ifc.req = 4'b0110;
        pushc(3, 4'b0010, 2'd1);
        repeat (3) tick();
        ifc.req = 4'b0101;
        pushc(3, 4'b0001, 2'd1);
        push("C_owner", 22, 128'd0, 3);
        repeat (3) tick();
        ifc.req = '0;
        repeat (4) tick();

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
